// File: rtl/spike_encoder_pkg.sv
// Shared constants and types for the spike encoder and the neuron array.
// Contents:
//   NUM_CH, RATE_W, HIST_W, SEL_W - channel count and field widths
//   state_t                      - encoder run state (ST_IDLE / ST_RUN)
//   shift_hist()                 - pushes a new spike into a history word
package spike_pkg;

    localparam int NUM_CH = 4;
    localparam int RATE_W = 4;
    localparam int HIST_W = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Newest spike enters bit 0; the oldest history bit falls off the top.
    function automatic logic [HIST_W-1:0] shift_hist(input logic [HIST_W-1:0] hist,
                                                     input logic spike);
        return {hist[HIST_W-2:0], spike};
    endfunction

endpackage

// File: rtl/spike_encoder_if.sv
// Rate-load handshake between the host/IO path and the spike encoder.
// Signals:
//   rate_data  - new rate value 0..15
//   rate_sel   - target channel 0..3
//   rate_valid - load request (held with data stable until accepted)
//   rate_ready - encoder load buffer is free
// Modports: master = host side, slave = encoder side.
interface spike_encoder_if;
    import spike_pkg::*;

    logic [RATE_W-1:0] rate_data;
    logic [SEL_W-1:0]  rate_sel;
    logic              rate_valid;
    logic              rate_ready;

    modport master (output rate_data, output rate_sel, output rate_valid, input rate_ready);
    modport slave  (input rate_data, input rate_sel, input rate_valid, output rate_ready);

endinterface

// File: rtl/spike_encoder_channel.sv
// One rate-coded spike channel: rate register, phase accumulator and
// spike history shift register.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   tick_i      - advance the accumulator by one encoder tick
//   load_i      - replace the rate with load_val_i
//   load_val_i  - new rate value
//   hist_o      - spike history, bit 0 is the newest tick's spike
module spike_channel
    import spike_pkg::*;
#(
    parameter int ACC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic              load_i,
    input  logic [RATE_W-1:0] load_val_i,
    output logic [HIST_W-1:0] hist_o
);

    logic [RATE_W-1:0] rate_q, rate_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [RATE_W-1:0] rate_use_s;
    logic [ACC_W:0]    inc_s;
    logic [ACC_W:0]    sum_s;

    // Next-state: a load landing on a tick edge feeds that same tick's sum.
    always_comb begin
        rate_use_s = load_i ? load_val_i : rate_q;
        inc_s      = (ACC_W+1)'(rate_use_s) << (ACC_W - 4);
        sum_s      = {1'b0, acc_q} + inc_s;
        rate_d     = rate_use_s;
        if (tick_i) begin
            acc_d  = sum_s[ACC_W-1:0];
            hist_d = shift_hist(hist_q, sum_s[ACC_W]);
        end else begin
            acc_d  = acc_q;
            hist_d = hist_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_q <= '0;
            acc_q  <= '0;
            hist_q <= '0;
        end else begin
            rate_q <= rate_d;
            acc_q  <= acc_d;
            hist_q <= hist_d;
        end
    end

    assign hist_o = hist_q;

endmodule

// File: rtl/spike_encoder.sv
// Rate-coded spike-train generator feeding the neuron array.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   rate_if    - rate-load handshake (slave side)
//   en         - run enable
//   busy       - high while running
//   out1..out4 - per-channel spike history, bit 0 newest
module spike_encoder
    import spike_pkg::*;
#(
    parameter int ACC_W    = 4,
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              rst,
    spike_encoder_if.slave    rate_if,
    input  logic              en,
    output logic              busy,
    output logic [HIST_W-1:0] out1,
    output logic [HIST_W-1:0] out2,
    output logic [HIST_W-1:0] out3,
    output logic [HIST_W-1:0] out4
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              pend_q;
    logic [SEL_W-1:0]  pend_sel_q;
    logic [RATE_W-1:0] pend_data_q;

    logic              tick_s;
    logic              apply_s;
    logic              xfer_s;
    logic [HIST_W-1:0] hist_s [NUM_CH];

    // en is qualified here so that dropping en on the last count skips the tick.
    assign tick_s  = (state_q == ST_RUN) && en && (cnt_q == CNT_LAST);
    // The pending entry drains on a tick in RUN, or at the very next edge in IDLE.
    assign apply_s = pend_q && ((state_q == ST_IDLE) || tick_s);
    assign xfer_s  = rate_if.rate_valid && !pend_q;

    // Run FSM, prescaler and single-entry load buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_sel_q  <= '0;
            pend_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (en) state_q <= ST_RUN;
                    else    state_q <= ST_IDLE;
                end
                ST_RUN: begin
                    if (!en) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase

            // ready is !pend_q, so capture and drain never coincide.
            if (apply_s) begin
                pend_q <= 1'b0;
            end else if (xfer_s) begin
                pend_q      <= 1'b1;
                pend_sel_q  <= rate_if.rate_sel;
                pend_data_q <= rate_if.rate_data;
            end else begin
                pend_q <= pend_q;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        spike_channel #(.ACC_W(ACC_W)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick_i     (tick_s),
            .load_i     (apply_s && (pend_sel_q == SEL_W'(i))),
            .load_val_i (pend_data_q),
            .hist_o     (hist_s[i])
        );
    end

    assign rate_if.rate_ready = !pend_q;
    assign busy = (state_q == ST_RUN);
    assign out1 = hist_s[0];
    assign out2 = hist_s[1];
    assign out3 = hist_s[2];
    assign out4 = hist_s[3];

endmodule

// File: tb/tb_spike_encoder.sv
// Directed self-checking bench: one encoder with PRESCALE=1 (d1) and one
// with PRESCALE=4 (d4), both ACC_W=4, sharing clock and reset.
module tb_spike_encoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en1 = 1'b0;
    logic en4 = 1'b0;
    logic busy1, busy4;
    logic [3:0] d1_o1, d1_o2, d1_o3, d1_o4;
    logic [3:0] d4_o1, d4_o2, d4_o3, d4_o4;
    int n_checks = 0;
    int n_fail   = 0;

    spike_encoder_if if1 ();
    spike_encoder_if if4 ();

    always #5 clk = ~clk;

    spike_encoder #(.ACC_W(4), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .rate_if(if1), .en(en1), .busy(busy1),
        .out1(d1_o1), .out2(d1_o2), .out3(d1_o3), .out4(d1_o4));

    spike_encoder #(.ACC_W(4), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .rate_if(if4), .en(en4), .busy(busy4),
        .out1(d4_o1), .out2(d4_o2), .out3(d4_o3), .out4(d4_o4));

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        if1.rate_valid = 1'b0; if1.rate_sel = 2'd0; if1.rate_data = 4'd0;
        if4.rate_valid = 1'b0; if4.rate_sel = 2'd0; if4.rate_data = 4'd0;
        step(2);
        rst = 1'b0;
        step(1);
        n_checks++;
        if ({d1_o1, d1_o2, d1_o3, d1_o4} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_out1 got=%h want=0000", {d1_o1, d1_o2, d1_o3, d1_o4});
        end
        n_checks++;
        if ({d4_o1, d4_o2, d4_o3, d4_o4} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_out4 got=%h want=0000", {d4_o1, d4_o2, d4_o3, d4_o4});
        end
        n_checks++;
        if ({busy1, busy4, if1.rate_ready, if4.rate_ready} !== 4'b0011) begin
            n_fail++; $display("FAIL reset_flags got=%b want=0011", {busy1, busy4, if1.rate_ready, if4.rate_ready});
        end
    endtask

    task automatic test_alternating;
        logic [3:0] exp_bit;
        exp_bit = 4'b1010; // tick t expects exp_bit[t-1]
        if1.rate_sel = 2'd0; if1.rate_data = 4'd8; if1.rate_valid = 1'b1;
        step(1);
        if1.rate_valid = 1'b0;
        step(1);
        en1 = 1'b1;
        step(1);
        n_checks++;
        if (busy1 !== 1'b1) begin n_fail++; $display("FAIL alt_busy got=%b want=1", busy1); end
        for (int t = 0; t < 4; t++) begin
            step(1);
            n_checks++;
            if (d1_o1[0] !== exp_bit[t]) begin
                n_fail++; $display("FAIL alt_tick%0d got=%b want=%b", t + 1, d1_o1[0], exp_bit[t]);
            end
        end
        n_checks++;
        if (d1_o1 !== 4'b0101) begin n_fail++; $display("FAIL alt_out1 got=%b want=0101", d1_o1); end
        n_checks++;
        if ({d1_o2, d1_o3, d1_o4} !== 12'h000) begin
            n_fail++; $display("FAIL alt_others got=%h want=000", {d1_o2, d1_o3, d1_o4});
        end
        en1 = 1'b0;
        step(1);
        n_checks++;
        if (busy1 !== 1'b0 || d1_o1 !== 4'b0101) begin
            n_fail++; $display("FAIL alt_stop got busy=%b out1=%b want busy=0 out1=0101", busy1, d1_o1);
        end
    endtask

    task automatic test_near_full;
        int spikes;
        spikes = 0;
        if1.rate_sel = 2'd3; if1.rate_data = 4'd15; if1.rate_valid = 1'b1;
        step(1);
        if1.rate_valid = 1'b0;
        step(1);
        en1 = 1'b1;
        step(1);
        for (int t = 1; t <= 16; t++) begin
            step(1);
            spikes += int'(d1_o4[0]);
            if (t == 1) begin
                n_checks++;
                if (d1_o4[0] !== 1'b0) begin n_fail++; $display("FAIL full_tick1 got=%b want=0", d1_o4[0]); end
            end
        end
        n_checks++;
        if (spikes != 15) begin n_fail++; $display("FAIL full_count got=%0d want=15", spikes); end
        // Accumulator back at 0: tick 17 repeats tick 1 (no spike), tick 18 spikes.
        step(1);
        n_checks++;
        if (d1_o4[0] !== 1'b0) begin n_fail++; $display("FAIL full_tick17 got=%b want=0", d1_o4[0]); end
        step(1);
        n_checks++;
        if (d1_o4 !== 4'b1101) begin n_fail++; $display("FAIL full_hist got=%b want=1101", d1_o4); end
        en1 = 1'b0;
        step(1);
    endtask

    task automatic test_load_idle;
        if1.rate_sel = 2'd2; if1.rate_data = 4'd5; if1.rate_valid = 1'b1;
        step(1);
        if1.rate_valid = 1'b0;
        n_checks++;
        if (if1.rate_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready_low got=%b want=0", if1.rate_ready); end
        step(1);
        n_checks++;
        if (if1.rate_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready_back got=%b want=1", if1.rate_ready); end
        step(1);
        n_checks++;
        if ({d1_o1, d1_o2, d1_o3, d1_o4} !== 16'h500d || busy1 !== 1'b0) begin
            n_fail++; $display("FAIL idle_outs got=%h busy=%b want=500d busy=0", {d1_o1, d1_o2, d1_o3, d1_o4}, busy1);
        end
    endtask

    task automatic test_prescaler;
        if4.rate_sel = 2'd1; if4.rate_data = 4'd8; if4.rate_valid = 1'b1;
        step(1);
        if4.rate_valid = 1'b0;
        step(1);
        en4 = 1'b1;
        step(1);                       // E0
        step(7);                       // E0+7, one tick (no spike) so far
        n_checks++;
        if (d4_o2 !== 4'b0000) begin n_fail++; $display("FAIL pre_e7 got=%b want=0000", d4_o2); end
        step(1);                       // E0+8, second tick spikes
        n_checks++;
        if (d4_o2 !== 4'b0001) begin n_fail++; $display("FAIL pre_e8 got=%b want=0001", d4_o2); end
        step(3);                       // cnt now 3
        en4 = 1'b0;
        step(1);
        n_checks++;
        if (busy4 !== 1'b0 || d4_o2 !== 4'b0001) begin
            n_fail++; $display("FAIL pre_drop got busy=%b out2=%b want busy=0 out2=0001", busy4, d4_o2);
        end
        step(2);
        en4 = 1'b1;
        step(1);                       // E1: full period restarts
        step(3);
        n_checks++;
        if (d4_o2 !== 4'b0001) begin n_fail++; $display("FAIL pre_re3 got=%b want=0001", d4_o2); end
        step(1);
        n_checks++;
        if (d4_o2 !== 4'b0010) begin n_fail++; $display("FAIL pre_re4 got=%b want=0010", d4_o2); end
    endtask

    task automatic test_back_to_back;
        // Entered right after a tick edge, cnt=0.
        if4.rate_sel = 2'd0; if4.rate_data = 4'd3; if4.rate_valid = 1'b1;
        step(1);
        if4.rate_data = 4'd12;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (if4.rate_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall%0d got=%b want=0", k, if4.rate_ready); end
            step(1);
        end
        // This edge was the tick that consumed rate 3.
        n_checks++;
        if (if4.rate_ready !== 1'b1 || d4_o1 !== 4'b0000) begin
            n_fail++; $display("FAIL b2b_tick got ready=%b out1=%b want ready=1 out1=0000", if4.rate_ready, d4_o1);
        end
        step(1);
        if4.rate_valid = 1'b0;
        n_checks++;
        if (if4.rate_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second got=%b want=0", if4.rate_ready); end
        step(3);
        n_checks++;
        if (if4.rate_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_drain got=%b want=1", if4.rate_ready); end
        // acc: 3, 15, 27->11 s, 23->7 s, 19->3 s, 15
        step(16);
        n_checks++;
        if (d4_o1 !== 4'b1110) begin n_fail++; $display("FAIL b2b_hist got=%b want=1110", d4_o1); end
    endtask

    task automatic test_async_reset;
        if4.rate_sel = 2'd2; if4.rate_data = 4'd9; if4.rate_valid = 1'b1;
        step(1);
        if4.rate_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({d4_o1, d4_o2, d4_o3, d4_o4} !== 16'h0000 || if4.rate_ready !== 1'b1 || busy4 !== 1'b0) begin
            n_fail++; $display("FAIL arst_now got outs=%h ready=%b busy=%b want 0000/1/0",
                               {d4_o1, d4_o2, d4_o3, d4_o4}, if4.rate_ready, busy4);
        end
        #1;
        rst = 1'b0;
        step(1);
        n_checks++;
        if (busy4 !== 1'b1) begin n_fail++; $display("FAIL arst_rerun got=%b want=1", busy4); end
        step(32);
        n_checks++;
        if ({d4_o1, d4_o2, d4_o3, d4_o4} !== 16'h0000) begin
            n_fail++; $display("FAIL arst_silent got=%h want=0000", {d4_o1, d4_o2, d4_o3, d4_o4});
        end
        en4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_near_full();
        test_load_idle();
        test_prescaler();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
